// File: rtl/m_fetch_redirect_ctrl_pkg.sv
// Shared fetch-control types: FSM state encoding, redirect kinds and the
// one-entry pending-redirect buffer layout.
package m_fetch_redirect_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MISS = 2'd2
    } fetch_state_e;

    typedef enum logic {
        KIND_BRANCH = 1'b0,
        KIND_JUMP   = 1'b1
    } redir_kind_e;

    typedef struct packed {
        logic              valid;
        redir_kind_e       kind;
        logic [ADDR_W-1:0] target;
    } pend_buf_t;

endpackage

// File: rtl/m_fetch_watchdog.sv
// Saturating idle-cycle watchdog. expired is high while the count sits at
// its maximum; clear wins over hold, hold freezes the count.
module m_fetch_watchdog #(
    parameter int unsigned WDT_W = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    input  logic hold,
    output logic expired
);

    localparam logic [WDT_W-1:0] CNT_MAX = '1;

    logic [WDT_W-1:0] count_q;

    // Count idle cycles, saturating at the maximum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && !hold && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == CNT_MAX);

endmodule

// File: rtl/m_fetch_redirect_ctrl.sv
// Fetch redirect controller: IDLE/RUN/MISS fetch FSM, prioritised PC
// redirects (exception > pending > branch > jump > panic), a one-entry
// buffer for redirects that arrive while fetch is stalled, and a
// no-retire watchdog that forces a panic redirect. All outputs are
// combinational so a redirect reaches the PC in the cycle it is requested.
module m_fetch_redirect_ctrl
    import m_fetch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned WDT_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_miss,
    input  logic              ic_refill_done,
    input  logic              ex_stall,
    input  logic              retire,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              pc_stall,
    output logic              pc_exception,
    output logic              pc_branch,
    output logic              pc_jump,
    output logic              pc_panic,
    output logic [ADDR_W-1:0] pc_target,
    output logic              fetch_valid,
    output logic              flush,
    output logic              ovf_sticky,
    output fetch_state_e      state_dbg
);

    fetch_state_e state_q, state_d;
    pend_buf_t    pend_q, pend_d;
    logic         ovf_q, ovf_d;
    logic         stalled;
    logic         wdt_en, wdt_clear, wdt_hold, wdt_expired;

    // State, pending buffer and sticky overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state, buffer update and all PC control outputs.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        pc_stall     = 1'b0;
        pc_exception = 1'b0;
        pc_branch    = 1'b0;
        pc_jump      = 1'b0;
        pc_panic     = 1'b0;
        pc_target    = '0;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        stalled      = (state_q == ST_MISS) | ex_stall | ic_miss;

        case (state_q)
            ST_IDLE: begin
                // PC holds its reset address for one cycle, then fetch starts.
                pc_stall = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN, ST_MISS: begin
                fetch_valid = (state_q == ST_RUN) && !stalled;
                if (exc_req) begin
                    // Exceptions override stalls and abort an outstanding miss.
                    pc_exception = 1'b1;
                    pc_target    = exc_target;
                    flush        = 1'b1;
                    pend_d       = '0;
                    state_d      = ST_RUN;
                end else if (stalled) begin
                    pc_stall = 1'b1;
                    // Park the redirect; a branch may displace a parked jump.
                    if (branch_req || jump_req) begin
                        if (!pend_q.valid) begin
                            pend_d.valid  = 1'b1;
                            pend_d.kind   = branch_req ? KIND_BRANCH : KIND_JUMP;
                            pend_d.target = branch_req ? branch_target : jump_target;
                        end else if (branch_req && (pend_q.kind == KIND_JUMP)) begin
                            pend_d.valid  = 1'b1;
                            pend_d.kind   = KIND_BRANCH;
                            pend_d.target = branch_target;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if ((state_q == ST_RUN) && ic_miss) begin
                        state_d = ST_MISS;
                    end
                    if ((state_q == ST_MISS) && ic_refill_done) begin
                        state_d = ST_RUN;
                    end
                end else if (pend_q.valid) begin
                    // Parked redirect goes first; new requests are squashed by it.
                    pc_branch = (pend_q.kind == KIND_BRANCH);
                    pc_jump   = (pend_q.kind == KIND_JUMP);
                    pc_target = pend_q.target;
                    flush     = 1'b1;
                    pend_d    = '0;
                end else if (branch_req) begin
                    pc_branch = 1'b1;
                    pc_target = branch_target;
                    flush     = 1'b1;
                end else if (jump_req) begin
                    pc_jump   = 1'b1;
                    pc_target = jump_target;
                    flush     = 1'b1;
                end else if (wdt_expired) begin
                    pc_panic = 1'b1;
                    flush    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Watchdog control: count live cycles, clear on progress or redirect,
    // freeze an expired count while the panic has to wait out a stall.
    always_comb begin
        wdt_en    = (state_q != ST_IDLE);
        wdt_clear = retire | pc_exception | pc_branch | pc_jump | pc_panic;
        wdt_hold  = stalled & wdt_expired;
    end

    m_fetch_watchdog #(
        .WDT_W (WDT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .count_en (wdt_en),
        .clear    (wdt_clear),
        .hold     (wdt_hold),
        .expired  (wdt_expired)
    );

    assign ovf_sticky = ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_m_fetch_redirect_ctrl.sv
// Bench for m_fetch_redirect_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model.
module tb_m_fetch_redirect_ctrl;

    localparam int WDT_W   = 4;
    localparam int CNT_MAX = (1 << WDT_W) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_MISS  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ic_miss, ic_refill_done, ex_stall, retire;
    logic        exc_req, branch_req, jump_req;
    logic [31:0] exc_target, branch_target, jump_target;
    logic        pc_stall, pc_exception, pc_branch, pc_jump, pc_panic;
    logic [31:0] pc_target;
    logic        fetch_valid, flush, ovf_sticky;
    logic [1:0]  state_dbg;

    m_fetch_redirect_ctrl #(.WDT_W(WDT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_miss        (ic_miss),
        .ic_refill_done (ic_refill_done),
        .ex_stall       (ex_stall),
        .retire         (retire),
        .exc_req        (exc_req),
        .exc_target     (exc_target),
        .branch_req     (branch_req),
        .branch_target  (branch_target),
        .jump_req       (jump_req),
        .jump_target    (jump_target),
        .pc_stall       (pc_stall),
        .pc_exception   (pc_exception),
        .pc_branch      (pc_branch),
        .pc_jump        (pc_jump),
        .pc_panic       (pc_panic),
        .pc_target      (pc_target),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .ovf_sticky     (ovf_sticky),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [41:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Architectural view: fetch mode, a parked redirect (if any), the number
    // of cycles since the last retire/redirect, and the overflow flag.
    int          m_state, n_state;
    bit          m_pv, n_pv, m_pbr, n_pbr;
    logic [31:0] m_pt, n_pt;
    int          m_cnt, n_cnt;
    bit          m_ovf, n_ovf;
    bit          e_stall, e_exc, e_br, e_jmp, e_pan, e_fv, e_flush;
    logic [31:0] e_tgt;

    function automatic void model_reset();
        m_state = M_IDLE; m_pv = 0; m_pbr = 0; m_pt = '0; m_cnt = 0; m_ovf = 0;
    endfunction

    function automatic void model_eval();
        bit st, redirect;
        n_state = m_state; n_pv = m_pv; n_pbr = m_pbr; n_pt = m_pt;
        n_cnt = m_cnt; n_ovf = m_ovf;
        e_stall = 0; e_exc = 0; e_br = 0; e_jmp = 0; e_pan = 0;
        e_fv = 0; e_flush = 0; e_tgt = '0; redirect = 0;
        if (m_state == M_IDLE) begin
            e_stall = 1;
            n_state = M_RUN;
        end else begin
            st   = (m_state == M_MISS) || ex_stall || ic_miss;
            e_fv = (m_state == M_RUN) && !st;
            if (exc_req) begin
                e_exc = 1; e_tgt = exc_target; e_flush = 1;
                n_pv = 0; redirect = 1; n_state = M_RUN;
            end else if (st) begin
                e_stall = 1;
                if (branch_req) begin
                    if (!m_pv || !m_pbr) begin
                        n_pv = 1; n_pbr = 1; n_pt = branch_target;
                    end else n_ovf = 1;
                end else if (jump_req) begin
                    if (!m_pv) begin
                        n_pv = 1; n_pbr = 0; n_pt = jump_target;
                    end else n_ovf = 1;
                end
                if (m_state == M_RUN && ic_miss) n_state = M_MISS;
                if (m_state == M_MISS && ic_refill_done) n_state = M_RUN;
            end else if (m_pv) begin
                if (m_pbr) e_br = 1; else e_jmp = 1;
                e_tgt = m_pt; e_flush = 1; n_pv = 0; redirect = 1;
            end else if (branch_req) begin
                e_br = 1; e_tgt = branch_target; e_flush = 1; redirect = 1;
            end else if (jump_req) begin
                e_jmp = 1; e_tgt = jump_target; e_flush = 1; redirect = 1;
            end else if (m_cnt == CNT_MAX) begin
                e_pan = 1; e_flush = 1; redirect = 1;
            end
            if (redirect || retire) n_cnt = 0;
            else if (m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void model_commit();
        m_state = n_state; m_pv = n_pv; m_pbr = n_pbr; m_pt = n_pt;
        m_cnt = n_cnt; m_ovf = n_ovf;
    endfunction

    // ---------------- drivers ----------------
    logic [41:0] o_vec;

    task automatic clear_inputs();
        ic_miss = 0; ic_refill_done = 0; ex_stall = 0; retire = 1;
        exc_req = 0; branch_req = 0; jump_req = 0;
        exc_target = '0; branch_target = '0; jump_target = '0;
    endtask

    task automatic sample_check();
        logic [41:0] e;
        model_eval();
        exp_q.push_back({e_stall, e_exc, e_br, e_jmp, e_pan, e_fv, e_flush, m_ovf,
                         2'(m_state), e_tgt});
        #2;
        o_vec = {pc_stall, pc_exception, pc_branch, pc_jump, pc_panic, fetch_valid,
                 flush, ovf_sticky, state_dbg, pc_target};
        e = exp_q.pop_front();
        check("ctl", 32'(o_vec[41:34]), 32'(e[41:34]));
        check("state", 32'(o_vec[33:32]), 32'(e[33:32]));
        check("target", o_vec[31:0], e[31:0]);
    endtask

    task automatic step();
        sample_check();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 0;
        #1;
        model_reset();
        sample_check();
        check("rst_outputs", 32'(o_vec[41:32]), 32'h200);
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic drive_random(input int retire_pct);
        ic_miss        = ($urandom_range(0, 99) < 10);
        ic_refill_done = ($urandom_range(0, 99) < 25);
        ex_stall       = ($urandom_range(0, 99) < 15);
        retire         = ($urandom_range(0, 99) < retire_pct);
        exc_req        = ($urandom_range(0, 99) < 3);
        branch_req     = ($urandom_range(0, 99) < 15);
        jump_req       = ($urandom_range(0, 99) < 15);
        exc_target     = $urandom;
        branch_target  = $urandom;
        jump_target    = $urandom;
    endtask

    // ---------------- stimulus ----------------
    int panics;

    initial begin
        clear_inputs();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sample_check();
        @(posedge clk);
        #1;
        reset = 1;

        // Reset release: one IDLE cycle, then RUN fetching.
        step();
        check("idle_stall", 32'(o_vec[41]), 32'd1);
        step();
        check("run_fetch", 32'(o_vec[36]), 32'd1);
        check("run_nostall", 32'(o_vec[41]), 32'd0);

        // Branch and jump together while running: branch forwarded.
        branch_req = 1; branch_target = 32'h1040; jump_req = 1; jump_target = 32'h2222;
        step();
        check("bj_branch", 32'(o_vec[39]), 32'd1);
        check("bj_nojump", 32'(o_vec[38]), 32'd0);
        check("bj_target", o_vec[31:0], 32'h1040);
        clear_inputs();

        // Miss, park a jump, overwrite with a branch, refill, issue.
        ic_miss = 1; step(); clear_inputs();
        step();
        jump_req = 1; jump_target = 32'h1100; step(); clear_inputs();
        branch_req = 1; branch_target = 32'h1200; step(); clear_inputs();
        ic_refill_done = 1; step();
        check("refill_stall", 32'(o_vec[41]), 32'd1);
        clear_inputs();
        step();
        check("pend_branch", 32'(o_vec[39]), 32'd1);
        check("pend_target", o_vec[31:0], 32'h1200);
        check("pend_noovf", 32'(o_vec[34]), 32'd0);

        // Exception during a miss with a parked branch.
        ic_miss = 1; step(); clear_inputs();
        branch_req = 1; branch_target = 32'h1300; step(); clear_inputs();
        exc_req = 1; exc_target = 32'h3000; step();
        check("exc_strobe", 32'(o_vec[40]), 32'd1);
        check("exc_target", o_vec[31:0], 32'h3000);
        check("exc_nostall", 32'(o_vec[41]), 32'd0);
        clear_inputs();
        step();
        check("exc_run", 32'(o_vec[33:32]), 32'd1);
        check("exc_bufempty", 32'(o_vec[39]), 32'd0);

        // Watchdog: one panic in 20 idle cycles, then a stall-deferred panic.
        step();
        retire = 0;
        panics = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            panics += int'(o_vec[37]);
        end
        check("wdt_one_panic", 32'(panics), 32'd1);
        retire = 1; step(); retire = 0;
        repeat (15) step();
        ex_stall = 1;
        panics = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            panics += int'(o_vec[37]);
        end
        check("wdt_deferred", 32'(panics), 32'd0);
        ex_stall = 0;
        step();
        check("wdt_late_panic", 32'(o_vec[37]), 32'd1);
        clear_inputs();

        // Overflow on a second jump while stalled; original jump kept.
        ex_stall = 1; jump_req = 1; jump_target = 32'h1500; step();
        jump_target = 32'h1600; step();
        jump_req = 0; step();
        check("ovf_set", 32'(o_vec[34]), 32'd1);
        ex_stall = 0; step();
        check("ovf_keep_jump", 32'(o_vec[38]), 32'd1);
        check("ovf_keep_tgt", o_vec[31:0], 32'h1500);
        // Park a jump, then reset: nothing must come out afterwards.
        ex_stall = 1; jump_req = 1; jump_target = 32'h1700; step();
        clear_inputs();
        pulse_reset();
        panics = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            panics += int'(o_vec[39] | o_vec[38]);
        end
        check("rst_no_redirect", 32'(panics), 32'd0);

        // Random traffic: frequent retire, then sparse retire for panics.
        for (int i = 0; i < 3000; i++) begin
            drive_random(i < 1500 ? 40 : 3);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
